// File: rtl/alu_lockstep_sched.sv
// Round-robin scheduler and lockstep checker for the dual 4-bit ALU pair.
// Each accepted operation drives both lanes, then compares the results and returns a response.
module alu_lockstep_sched #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned ERR_W   = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [3:0]       req0_a_i,
    input  logic [3:0]       req0_b_i,
    input  logic [1:0]       req0_sel_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [3:0]       req1_a_i,
    input  logic [3:0]       req1_b_i,
    input  logic [1:0]       req1_sel_i,
    input  logic             inj_i,
    output logic [3:0]       alu_a0_o,
    output logic [3:0]       alu_b0_o,
    output logic [3:0]       alu_a1_o,
    output logic [3:0]       alu_b1_o,
    output logic [1:0]       alu_sel1_o,
    output logic [1:0]       alu_sel2_o,
    input  logic [3:0]       alu_out1_i,
    input  logic [3:0]       alu_out2_i,
    input  logic             alu_c1_i,
    input  logic             alu_c2_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [4:0]       rsp_data_o,
    output logic             rsp_mis_o,
    input  logic             clr_err_i,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             err_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {StIdle, StWait, StCheck, StResp} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             rr_last_q, rr_last_d;
    logic [3:0]       a0_q, a1_q, b_q;
    logic [1:0]       sel_q;
    logic             id_q;
    logic             rsp_id_q, rsp_mis_q;
    logic [4:0]       rsp_data_q;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_q, err_d;
    logic             grant0, grant1, accept, mis;

    // rr_last_q holds the id served last; with both valid the other one wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant0 = rr_last_q;
            grant1 = ~rr_last_q;
        end else begin
            grant0 = req0_valid_i;
            grant1 = req1_valid_i;
        end
    end

    assign req0_ready_o = ~wb_rst_i & (state_q == StIdle) & grant0;
    assign req1_ready_o = ~wb_rst_i & (state_q == StIdle) & grant1;
    assign accept       = req0_ready_o | req1_ready_o;
    assign mis          = (alu_out1_i != alu_out2_i) | (alu_c1_i != alu_c2_i);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = 4'(ALU_LAT);
                end
            end
            StWait: begin
                if (cnt_q == 4'd1) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCheck: state_d = StResp;
            StResp: begin
                if (rsp_ready_i) begin
                    state_d   = StIdle;
                    rr_last_d = rsp_id_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Clear takes effect first, so a mismatch in the same cycle still counts.
    always_comb begin
        err_cnt_d = clr_err_i ? '0 : err_cnt_q;
        err_d     = clr_err_i ? 1'b0 : err_q;
        if ((state_q == StCheck) && mis) begin
            err_d = 1'b1;
            if (err_cnt_d != '1) begin
                err_cnt_d = err_cnt_d + {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            rr_last_q <= 1'b1;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            a0_q       <= 4'd0;
            a1_q       <= 4'd0;
            b_q        <= 4'd0;
            sel_q      <= 2'd0;
            id_q       <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= 5'd0;
            rsp_mis_q  <= 1'b0;
        end else begin
            if (accept) begin
                a0_q  <= req1_ready_o ? req1_a_i : req0_a_i;
                a1_q  <= (req1_ready_o ? req1_a_i : req0_a_i) ^ {3'b000, inj_i};
                b_q   <= req1_ready_o ? req1_b_i : req0_b_i;
                sel_q <= req1_ready_o ? req1_sel_i : req0_sel_i;
                id_q  <= req1_ready_o;
            end
            if (state_q == StCheck) begin
                rsp_id_q   <= id_q;
                rsp_data_q <= {alu_c1_i, alu_out1_i};
                rsp_mis_q  <= mis;
            end
        end
    end

    assign alu_a0_o    = a0_q;
    assign alu_a1_o    = a1_q;
    assign alu_b0_o    = b_q;
    assign alu_b1_o    = b_q;
    assign alu_sel1_o  = sel_q;
    assign alu_sel2_o  = sel_q;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_mis_o   = rsp_mis_q;
    assign err_cnt_o   = err_cnt_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_lockstep_sched.sv
// Scoreboard bench for alu_lockstep_sched: accepted ops push expected responses,
// a response monitor pops and compares; the ALU pair is modelled combinationally.
module tb_alu_lockstep_sched;
    localparam int unsigned LAT = 4;
    localparam int unsigned EW  = 8;
    localparam int          ERR_MAX = (1 << EW) - 1;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic          req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
    logic [3:0]    req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic [1:0]    req0_sel_i, req1_sel_i;
    logic          inj_i;
    logic [3:0]    alu_a0_o, alu_b0_o, alu_a1_o, alu_b1_o;
    logic [1:0]    alu_sel1_o, alu_sel2_o;
    logic [3:0]    alu_out1_i, alu_out2_i;
    logic          alu_c1_i, alu_c2_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_mis_o;
    logic [4:0]    rsp_data_o;
    logic          clr_err_i;
    logic [EW-1:0] err_cnt_o;
    logic          err_o, busy_o;

    always #5 wb_clk_i = ~wb_clk_i;

    alu_lockstep_sched #(.ALU_LAT(LAT), .ERR_W(EW)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_sel_i(req0_sel_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_sel_i(req1_sel_i),
        .inj_i(inj_i),
        .alu_a0_o(alu_a0_o), .alu_b0_o(alu_b0_o), .alu_a1_o(alu_a1_o), .alu_b1_o(alu_b1_o),
        .alu_sel1_o(alu_sel1_o), .alu_sel2_o(alu_sel2_o),
        .alu_out1_i(alu_out1_i), .alu_out2_i(alu_out2_i),
        .alu_c1_i(alu_c1_i), .alu_c2_i(alu_c2_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o), .rsp_mis_o(rsp_mis_o),
        .clr_err_i(clr_err_i), .err_cnt_o(err_cnt_o), .err_o(err_o), .busy_o(busy_o)
    );

    // ALU model: 0 add (with carry), 1 xor, 2 and, 3 or.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] sel);
        case (sel)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a ^ b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign {alu_c1_i, alu_out1_i} = alu_f(alu_a0_o, alu_b0_o, alu_sel1_o);
    assign {alu_c2_i, alu_out2_i} = alu_f(alu_a1_o, alu_b1_o, alu_sel2_o);

    typedef struct packed {
        logic       id;
        logic [4:0] data;
        logic       mis;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         last_served = -1;
    int         exp_cnt = 0;
    logic       exp_err = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_id, prev_mis;
    logic [4:0] prev_data;
    logic       got_id, got_mis;
    logic [4:0] got_data;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_alu"}, {req0_ready_o, req1_ready_o, alu_a0_o, alu_b0_o, alu_a1_o,
                             alu_b1_o, alu_sel1_o, alu_sel2_o}, 64'd0);
        chk({name, "_rsp"}, {rsp_valid_o, rsp_id_o, rsp_data_o, rsp_mis_o, err_cnt_o,
                             err_o, busy_o}, 64'd0);
    endtask

    // Accept monitor: checks arbitration against the model and pushes the expected response.
    always begin
        @(negedge wb_clk_i);
        if (!wb_rst_i && !busy_o) begin
            int         w;
            logic [3:0] a, b;
            logic [1:0] sel;
            logic       inj;
            logic [4:0] r0, r1;
            w = -1;
            if (req0_valid_i && req1_valid_i) w = (last_served == 0) ? 1 : 0;
            else if (req0_valid_i) w = 0;
            else if (req1_valid_i) w = 1;
            chk("grant0", req0_ready_o, w == 0);
            chk("grant1", req1_ready_o, w == 1);
            if (w >= 0) begin
                a   = (w == 1) ? req1_a_i : req0_a_i;
                b   = (w == 1) ? req1_b_i : req0_b_i;
                sel = (w == 1) ? req1_sel_i : req0_sel_i;
                inj = inj_i;
                r0  = alu_f(a, b, sel);
                r1  = alu_f(inj ? (a ^ 4'h1) : a, b, sel);
                sb.push_back('{id: (w == 1), data: r0, mis: (r0 != r1)});
                acc_cyc = cyc;
                @(posedge wb_clk_i);
                #1;
                chk("alu_a0", alu_a0_o, a);
                chk("alu_a1", alu_a1_o, inj ? (a ^ 4'h1) : a);
                chk("alu_b", {alu_b0_o, alu_b1_o}, {b, b});
                chk("alu_sel", {alu_sel1_o, alu_sel2_o}, {sel, sel});
                chk("busy_after_accept", {busy_o, req0_ready_o, req1_ready_o}, 3'b100);
            end
        end
    end

    // Response monitor: latency, hold stability, scoreboard pop and error model.
    always begin
        @(negedge wb_clk_i);
        if (wb_rst_i) begin
            prev_valid = 1'b0;
        end else begin
            if (clr_err_i) begin
                exp_cnt = 0;
                exp_err = 1'b0;
            end
            if (rsp_valid_o) begin
                if (!prev_valid) chk("rsp_latency", cyc, acc_cyc + 2 + LAT);
                else chk("rsp_hold", {rsp_id_o, rsp_data_o, rsp_mis_o},
                         {prev_id, prev_data, prev_mis});
                prev_id   = rsp_id_o;
                prev_data = rsp_data_o;
                prev_mis  = rsp_mis_o;
                if (rsp_ready_i) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp actual=valid required=none");
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("rsp_id", rsp_id_o, e.id);
                        chk("rsp_data", rsp_data_o, e.data);
                        chk("rsp_mis", rsp_mis_o, e.mis);
                        if (e.mis) begin
                            exp_err = 1'b1;
                            if (exp_cnt < ERR_MAX) exp_cnt++;
                        end
                        chk("err_cnt", err_cnt_o, exp_cnt);
                        chk("err_flag", err_o, exp_err);
                        last_served = e.id ? 1 : 0;
                        got_id   = rsp_id_o;
                        got_data = rsp_data_o;
                        got_mis  = rsp_mis_o;
                    end
                    prev_valid = 1'b0;
                end else begin
                    prev_valid = 1'b1;
                end
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic set_req(input logic id, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] sel);
        if (id) begin
            req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b; req1_sel_i = sel;
        end else begin
            req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b; req0_sel_i = sel;
        end
    endtask

    task automatic wait_accept(input logic id);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge wb_clk_i);
            ok = id ? req1_ready_o : req0_ready_o;
        end
        chk("op_accept", ok, 1'b1);
    endtask

    task automatic wait_rsp();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge wb_clk_i);
            ok = rsp_valid_o && rsp_ready_i;
        end
        chk("op_response", ok, 1'b1);
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] sel, input logic inj);
        set_req(id, a, b, sel);
        inj_i       = inj;
        rsp_ready_i = 1'b1;
        wait_accept(id);
        @(posedge wb_clk_i);
        #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        inj_i        = 1'b0;
        wait_rsp();
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge wb_clk_i);
            ok = !busy_o && (sb.size() == 0);
        end
        chk("drain_idle", ok, 1'b1);
        @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ok;
        wb_rst_i = 1'b1;
        {req0_valid_i, req1_valid_i, inj_i, clr_err_i} = '0;
        {req0_a_i, req0_b_i, req1_a_i, req1_b_i, req0_sel_i, req1_sel_i} = '0;
        rsp_ready_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1;
        check_zero("reset");
        wb_rst_i = 1'b0;

        // Single add: 3 + 5 = 8 on requester 0.
        do_op(1'b0, 4'h3, 4'h5, 2'd0, 1'b0);
        chk("t1_data", got_data, 5'h08);
        chk("t1_id_mis", {got_id, got_mis}, 2'b00);

        // Injected fault on requester 1: lane 1 sees A=3.
        do_op(1'b1, 4'h2, 4'h2, 2'd0, 1'b1);
        chk("t3_mis", got_mis, 1'b1);
        chk("t3_err", {err_cnt_o, err_o}, {8'd1, 1'b1});

        // Both requesters valid continuously: grants must alternate.
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 80; i++) begin
            set_req(1'b0, 4'($urandom), 4'($urandom), 2'($urandom));
            set_req(1'b1, 4'($urandom), 4'($urandom), 2'($urandom));
            @(posedge wb_clk_i);
            #1;
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        wait_idle();

        // Randomized traffic with back-pressure and occasional fault injection.
        for (int i = 0; i < 500; i++) begin
            req0_valid_i = 1'($urandom);
            req1_valid_i = 1'($urandom);
            req0_a_i = 4'($urandom); req0_b_i = 4'($urandom); req0_sel_i = 2'($urandom);
            req1_a_i = 4'($urandom); req1_b_i = 4'($urandom); req1_sel_i = 2'($urandom);
            inj_i       = ($urandom_range(0, 3) == 0);
            rsp_ready_i = ($urandom_range(0, 2) != 0);
            @(posedge wb_clk_i);
            #1;
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        inj_i        = 1'b0;
        rsp_ready_i  = 1'b1;
        wait_idle();

        // Hold the response for 10 cycles with both requesters pending.
        rsp_ready_i = 1'b0;
        set_req(1'b0, 4'h9, 4'h6, 2'd1);
        wait_accept(1'b0);
        @(posedge wb_clk_i);
        #1;
        set_req(1'b1, 4'hc, 4'h7, 2'd0);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge wb_clk_i);
            ok = rsp_valid_o;
        end
        chk("hold_rsp_seen", ok, 1'b1);
        repeat (10) begin
            @(negedge wb_clk_i);
            chk("hold_state", {rsp_valid_o, req0_ready_o, req1_ready_o, busy_o}, 4'b1001);
        end
        @(posedge wb_clk_i);
        #1;
        rsp_ready_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge wb_clk_i);
            ok = req0_ready_o | req1_ready_o;
        end
        chk("hold_next_accept", ok, 1'b1);
        @(posedge wb_clk_i);
        #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        wait_idle();

        // Saturation of the mismatch counter.
        for (int i = 0; i < 300; i++) begin
            do_op(1'($urandom), 4'($urandom), 4'($urandom), 2'd0, 1'b1);
        end
        chk("sat_cnt", err_cnt_o, ERR_MAX);
        chk("sat_flag", err_o, 1'b1);

        // Clear coincident with a mismatch in the compare cycle.
        set_req(1'b0, 4'h4, 4'h1, 2'd0);
        inj_i = 1'b1;
        wait_accept(1'b0);
        @(posedge wb_clk_i);
        #1;
        req0_valid_i = 1'b0;
        inj_i        = 1'b0;
        repeat (LAT) @(posedge wb_clk_i);
        #1;
        clr_err_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        clr_err_i = 1'b0;
        wait_rsp();
        chk("clr_coincident", {err_cnt_o, err_o}, {8'd1, 1'b1});

        // Reset during the wait phase aborts the operation.
        set_req(1'b0, 4'h7, 4'h7, 2'd0);
        wait_accept(1'b0);
        @(posedge wb_clk_i);
        #1;
        req0_valid_i = 1'b0;
        #2;
        wb_rst_i = 1'b1;
        sb.delete();
        exp_cnt     = 0;
        exp_err     = 1'b0;
        last_served = -1;
        #1;
        check_zero("reset_mid_wait");
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        repeat (12) begin
            @(negedge wb_clk_i);
            chk("abort_no_rsp", rsp_valid_o, 1'b0);
        end
        @(posedge wb_clk_i);
        #1;
        do_op(1'b1, 4'ha, 4'h3, 2'd2, 1'b0);
        chk("post_reset_data", got_data, 5'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_lockstep_sched.md
Name: alu_lockstep_sched

Overview:
Scheduler and lockstep checker for the dual 4-bit ALU pair (alu_xor_4) in the user project area.
- Arbitrates round-robin between two requesters: 0 = host/Wishbone-side, 1 = GPIO-side.
- Issues each accepted operation to both ALU lanes simultaneously with identical operands and selects.
- Waits the ALU latency, samples both results, flags any lane disagreement, and returns a response to the winning requester.
- Maintains a saturating mismatch counter and a sticky error flag for the logic analyzer.

Parameters:
ALU_LAT, 1, cycles from operands driven to ALU outputs valid; legal range 1..15.
ERR_W, 8, width of the mismatch counter.

Ports:
wb_clk_i  in  1  clock (the only clock)
wb_rst_i  in  1  asynchronous active-high reset
req0_valid_i  in  1  requester 0 has an operation
req0_ready_o  out  1  requester 0 operation accepted this cycle
req0_a_i  in  4  requester 0 operand A
req0_b_i  in  4  requester 0 operand B
req0_sel_i  in  2  requester 0 ALU select
req1_valid_i / req1_ready_o / req1_a_i / req1_b_i / req1_sel_i  same as requester 0, for requester 1
inj_i  in  1  fault inject: sampled at accept; corrupts lane 1 operand A for that operation
alu_a0_o  out  4  ALU lane 0 operand A
alu_b0_o  out  4  ALU lane 0 operand B
alu_a1_o  out  4  ALU lane 1 operand A
alu_b1_o  out  4  ALU lane 1 operand B
alu_sel1_o  out  2  ALU lane 0 select
alu_sel2_o  out  2  ALU lane 1 select
alu_out1_i  in  4  ALU lane 0 result
alu_out2_i  in  4  ALU lane 1 result
alu_c1_i  in  1  ALU lane 0 carry
alu_c2_i  in  1  ALU lane 1 carry
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_id_o  out  1  requester the response belongs to
rsp_data_o  out  5  {carry, result} from lane 0
rsp_mis_o  out  1  lanes disagreed on this operation
clr_err_i  in  1  synchronous clear of err_cnt_o and err_o
err_cnt_o  out  ERR_W  saturating mismatch count
err_o  out  1  sticky mismatch flag
busy_o  out  1  state != IDLE

Behaviour:
Reset: all outputs 0, state IDLE, round-robin pointer favours requester 0.

States: IDLE -> WAIT -> CHECK -> RESP -> IDLE.

IDLE:
- Grant is combinational. Only one valid: that requester wins. Both valid: the requester not granted last wins.
- reqN_ready_o = (state==IDLE) & grantN; never both high.
- Accept at cycle T when valid & ready.
- At T, register operands, selects, id and inj into the ALU output registers and go to WAIT with count = ALU_LAT.

ALU drive:
- alu_a0_o = alu_a1_o = A, except alu_a1_o = A ^ 4'b0001 when inj was sampled high.
- B and sel are identical on both lanes.
- Values are stable from T+1 until the next accept.

WAIT: decrement count each cycle; when count reaches 1, go to CHECK. Sampling therefore occurs at cycle T+1+ALU_LAT.

CHECK:
- Capture rsp_data_o = {alu_c1_i, alu_out1_i}.
- rsp_mis_o = (alu_out1_i != alu_out2_i) | (alu_c1_i != alu_c2_i).
- Go to RESP.

RESP:
- rsp_valid_o is high from T+2+ALU_LAT and holds with stable data until rsp_ready_i.
- The cycle rsp_valid & rsp_ready both high, return to IDLE and update the round-robin pointer to the served id.
- A new accept is possible on the following cycle; no request is accepted while busy.

Error tracking:
- err_cnt_o increments by 1 per mismatch, in the CHECK cycle, and saturates at 2^ERR_W-1 with no wrap.
- err_o is set on any mismatch.
- clr_err_i in the same cycle as a mismatch: clear applies first and the mismatch counts, giving err_cnt_o=1, err_o=1.

Other rules:
- Reset asserted mid-operation: immediate return to IDLE, the pending response is dropped, ALU outputs go to 0, and the counter and flag clear.
- Requester valid dropped before accept is legal; no accept occurs.
- Operands are sampled only at accept.

Test Plan:
1. Single op, ALU_LAT=1: req0 A=4'h3 B=4'h5 sel=0, model ALU add -> req0_ready_o high at T; alu_a0_o=alu_a1_o=3 at T+1; rsp_valid_o at T+3 with rsp_data_o=5'h08, rsp_id_o=0, rsp_mis_o=0.
2. Both requesters valid continuously, rsp_ready_i=1 -> grants alternate 0,1,0,1; no two consecutive grants to the same id.
3. inj_i=1 with A=4'h2, B=4'h2, add -> alu_a1_o=4'h3; rsp_mis_o=1; err_cnt_o=1; err_o=1.
4. 300 injected ops (ERR_W=8) -> err_cnt_o stops at 255. Then clr_err_i coincident with a mismatch -> err_cnt_o=1.
5. rsp_ready_i held low 10 cycles -> rsp_valid_o and data stable; req_ready_o low throughout; busy_o=1.
6. Assert wb_rst_i during WAIT (ALU_LAT=4) -> all outputs 0 immediately; rsp_valid_o never asserts for the aborted op; next request is accepted normally.
